// File: rtl/alu_pipe_if.sv
// alu_pipe_if: op/result handshake bundle between an op source (master)
// and the pipelined ALU (slave). Signal names keep the ALU's i/o suffixes.
interface alu_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [XLEN-1:0]  opr_a_i;
  logic [XLEN-1:0]  opr_b_i;
  logic [3:0]       alu_func_i;
  logic             word_op_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  alu_res_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output in_valid_i, opr_a_i, opr_b_i, alu_func_i, word_op_i, tag_i,
           flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_res_o, tag_o
  );

  modport slave (
    input  in_valid_i, opr_a_i, opr_b_i, alu_func_i, word_op_i, tag_i,
           flush_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_res_o, tag_o
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: integer ALU evaluated combinationally at the input and carried
// through STAGES valid/ready register stages together with a sideband tag.
// XLEN is 32 or 64; STAGES is 1..4. Opcodes follow the {funct7[5], funct3}
// packing: ADD=0 SLL=1 SLT=2 SLTU=3 XOR=4 SRL=5 OR=6 AND=7 SUB=8 SRA=13.
module alu_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic      clk,
  input  logic      resetn,
  alu_pipe_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd13;
  localparam int         SHW     = $clog2(XLEN);

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_res_full;
  logic [XLEN-1:0] w_res;

  assign w_a     = bus.opr_a_i;
  assign w_b     = bus.opr_b_i;
  assign w_shamt = w_b[SHW-1:0];

  // Full-width result; unknown encodings give zero.
  always_comb begin
    w_res_full = '0;
    case (bus.alu_func_i)
      OP_ADD:  w_res_full = w_a + w_b;
      OP_SUB:  w_res_full = w_a - w_b;
      OP_SLL:  w_res_full = w_a << w_shamt;
      OP_SRL:  w_res_full = w_a >> w_shamt;
      OP_SRA:  w_res_full = $signed(w_a) >>> w_shamt;
      OP_OR:   w_res_full = w_a | w_b;
      OP_AND:  w_res_full = w_a & w_b;
      OP_XOR:  w_res_full = w_a ^ w_b;
      OP_SLTU: w_res_full = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      OP_SLT:  w_res_full = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      default: w_res_full = '0;
    endcase
  end

  generate
    if (XLEN == 64) begin : g_word
      logic [31:0] w_a32;
      logic [31:0] w_b32;
      logic [4:0]  w_sh32;
      logic [31:0] w_res32;

      assign w_a32  = w_a[31:0];
      assign w_b32  = w_b[31:0];
      assign w_sh32 = w_b32[4:0];

      // RV64 *W flavour: 32-bit operation on the low halves.
      always_comb begin
        w_res32 = '0;
        case (bus.alu_func_i)
          OP_ADD:  w_res32 = w_a32 + w_b32;
          OP_SUB:  w_res32 = w_a32 - w_b32;
          OP_SLL:  w_res32 = w_a32 << w_sh32;
          OP_SRL:  w_res32 = w_a32 >> w_sh32;
          OP_SRA:  w_res32 = $signed(w_a32) >>> w_sh32;
          OP_OR:   w_res32 = w_a32 | w_b32;
          OP_AND:  w_res32 = w_a32 & w_b32;
          OP_XOR:  w_res32 = w_a32 ^ w_b32;
          OP_SLTU: w_res32 = {31'b0, (w_a32 < w_b32)};
          OP_SLT:  w_res32 = {31'b0, ($signed(w_a32) < $signed(w_b32))};
          default: w_res32 = '0;
        endcase
      end

      assign w_res = bus.word_op_i ? {{(XLEN-32){w_res32[31]}}, w_res32}
                                   : w_res_full;
    end else begin : g_noword
      assign w_res = w_res_full;
    end
  endgenerate

  logic [STAGES-1:0] r_vld;
  logic [XLEN-1:0]   r_res [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [STAGES-1:0] w_adv;   // stage k hands its contents onward this cycle
  logic [STAGES-1:0] w_load;  // stage k may take new contents this cycle

  // Backpressure chain from the consumer towards the input; never sees in_valid.
  always_comb begin
    w_adv  = '0;
    w_load = '0;
    w_adv[STAGES-1]  = bus.out_ready_i;
    w_load[STAGES-1] = ~r_vld[STAGES-1] | bus.out_ready_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k]  = w_load[k+1];
      w_load[k] = ~r_vld[k] | w_adv[k];
    end
  end

  // Stage registers: flush kills every valid; data only moves with a valid op.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_res[k] <= '0;
        r_tag[k] <= '0;
      end
    end else if (bus.flush_i) begin
      r_vld <= '0;
    end else begin
      if (w_load[0]) begin
        r_vld[0] <= bus.in_valid_i;
        if (bus.in_valid_i) begin
          r_res[0] <= w_res;
          r_tag[0] <= bus.tag_i;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_res[k] <= r_res[k-1];
            r_tag[k] <= r_tag[k-1];
          end
        end
      end
    end
  end

  assign bus.in_ready_o  = w_load[0];
  assign bus.out_valid_o = r_vld[STAGES-1] & ~bus.flush_i;
  assign bus.alu_res_o   = r_res[STAGES-1];
  assign bus.tag_o       = r_tag[STAGES-1];
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed bench for a 64-bit/2-stage and a 32-bit/1-stage
// alu_pipe; expected results are queued at transfer and checked on output.
module tb_alu_pipe;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd13;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst64_n;
  logic rst32_n;
  int   total = 0;
  int   bad   = 0;
  exp_t q64[$];
  exp_t q32[$];

  always #5 clk = ~clk;

  alu_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();
  alu_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();

  alu_pipe #(.XLEN(64), .STAGES(2), .TAG_W(5)) u64 (
    .clk(clk), .resetn(rst64_n), .bus(b64)
  );
  alu_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) u32 (
    .clk(clk), .resetn(rst32_n), .bus(b32)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send64(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic [4:0] t, input logic [63:0] e);
    int n;
    b64.in_valid_i = 1'b1; b64.alu_func_i = f; b64.opr_a_i = a; b64.opr_b_i = b;
    b64.word_op_i = w; b64.tag_i = t;
    n = 0;
    @(negedge clk);
    while (!b64.in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b64.in_ready_o) chk("send64_timeout", 64'(b64.in_ready_o), 64'd1);
    else q64.push_back('{res: e, tag: t});
    @(posedge clk); #1;
    b64.in_valid_i = 1'b0;
  endtask

  task automatic send32(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic w, input logic [4:0] t, input logic [31:0] e);
    int n;
    b32.in_valid_i = 1'b1; b32.alu_func_i = f; b32.opr_a_i = a; b32.opr_b_i = b;
    b32.word_op_i = w; b32.tag_i = t;
    n = 0;
    @(negedge clk);
    while (!b32.in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b32.in_ready_o) chk("send32_timeout", 64'(b32.in_ready_o), 64'd1);
    else q32.push_back('{res: 64'(e), tag: t});
    @(posedge clk); #1;
    b32.in_valid_i = 1'b0;
  endtask

  // Two-cycle latency on the 64-bit pipe, out_ready_i high, pipe otherwise empty.
  task automatic lat64(input string name, input logic [63:0] e, input logic [4:0] t);
    @(negedge clk);
    chk({name, "_early"}, 64'(b64.out_valid_o), 64'd0);
    @(negedge clk);
    chk({name, "_valid"}, 64'(b64.out_valid_o), 64'd1);
    chk({name, "_res"}, b64.alu_res_o, e);
    chk({name, "_tag"}, 64'(b64.tag_o), 64'(t));
    @(posedge clk); #1;
  endtask

  task automatic lat32(input string name, input logic [31:0] e, input logic [4:0] t);
    @(negedge clk);
    chk({name, "_valid"}, 64'(b32.out_valid_o), 64'd1);
    chk({name, "_res"}, 64'(b32.alu_res_o), 64'(e));
    chk({name, "_tag"}, 64'(b32.tag_o), 64'(t));
    @(posedge clk); #1;
  endtask

  task automatic drain64();
    int n;
    n = 0;
    while (q64.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain64", 64'(q64.size()), 64'd0);
  endtask

  // Scoreboard for the 64-bit pipe: flush/reset discard queued expectations.
  always @(negedge clk) begin
    exp_t e;
    if (!rst64_n || b64.flush_i) q64.delete();
    else if (b64.out_valid_o && b64.out_ready_i) begin
      if (q64.size() == 0) chk("sb64_unexpected", 64'(b64.out_valid_o), 64'd0);
      else begin
        e = q64.pop_front();
        chk("sb64_res", b64.alu_res_o, e.res);
        chk("sb64_tag", 64'(b64.tag_o), 64'(e.tag));
      end
    end
  end

  // Scoreboard for the 32-bit pipe.
  always @(negedge clk) begin
    exp_t e;
    if (!rst32_n || b32.flush_i) q32.delete();
    else if (b32.out_valid_o && b32.out_ready_i) begin
      if (q32.size() == 0) chk("sb32_unexpected", 64'(b32.out_valid_o), 64'd0);
      else begin
        e = q32.pop_front();
        chk("sb32_res", 64'(b32.alu_res_o), e.res);
        chk("sb32_tag", 64'(b32.tag_o), 64'(e.tag));
      end
    end
  end

  // Time limit so a stuck handshake still ends the run.
  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    b64.in_valid_i = 1'b0; b64.opr_a_i = '0; b64.opr_b_i = '0; b64.alu_func_i = '0;
    b64.word_op_i = 1'b0; b64.tag_i = '0; b64.flush_i = 1'b0; b64.out_ready_i = 1'b1;
    b32.in_valid_i = 1'b0; b32.opr_a_i = '0; b32.opr_b_i = '0; b32.alu_func_i = '0;
    b32.word_op_i = 1'b0; b32.tag_i = '0; b32.flush_i = 1'b0; b32.out_ready_i = 1'b1;
    rst64_n = 1'b0;
    rst32_n = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst64_out_valid", 64'(b64.out_valid_o), 64'd0);
    chk("rst64_in_ready", 64'(b64.in_ready_o), 64'd1);
    chk("rst64_res", b64.alu_res_o, 64'd0);
    chk("rst64_tag", 64'(b64.tag_o), 64'd0);
    chk("rst32_out_valid", 64'(b32.out_valid_o), 64'd0);
    chk("rst32_in_ready", 64'(b32.in_ready_o), 64'd1);
    @(posedge clk); #3;
    rst64_n = 1'b1;
    rst32_n = 1'b1;
    @(posedge clk); #1;

    send64(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5'd3, 64'd0);
    lat64("add_wrap", 64'd0, 5'd3);
    send64(OP_SRA, 64'h0000_0000_8000_0000, 64'h24, 1'b1, 5'd4, 64'hFFFF_FFFF_F800_0000);
    lat64("sraw", 64'hFFFF_FFFF_F800_0000, 5'd4);
    send64(OP_SRL, 64'h0000_0000_8000_0000, 64'h24, 1'b1, 5'd5, 64'h0000_0000_0800_0000);
    lat64("srlw", 64'h0000_0000_0800_0000, 5'd5);
    send64(OP_SLL, 64'd1, 64'h7F, 1'b0, 5'd6, 64'h8000_0000_0000_0000);
    lat64("sll63", 64'h8000_0000_0000_0000, 5'd6);
    send64(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 5'd7, 64'd1);
    lat64("slt", 64'd1, 5'd7);
    send64(OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 5'd8, 64'd0);
    lat64("sltu", 64'd0, 5'd8);

    // Streamed mix checked by the scoreboard only.
    send64(OP_SUB, 64'd5, 64'd7, 1'b0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE);
    send64(OP_XOR, 64'hF0F0, 64'hFF00, 1'b0, 5'd10, 64'h0FF0);
    send64(OP_OR, 64'hF0F0, 64'h0F00, 1'b0, 5'd11, 64'hFFF0);
    send64(OP_AND, 64'hF0F0, 64'hFF00, 1'b0, 5'd12, 64'hF000);
    send64(4'd15, 64'd1, 64'd1, 1'b0, 5'd13, 64'd0);
    send64(OP_SRA, 64'h8000_0000_0000_0000, 64'h44, 1'b0, 5'd14, 64'hF800_0000_0000_0000);
    send64(OP_ADD, 64'h7FFF_FFFF, 64'd1, 1'b1, 5'd15, 64'hFFFF_FFFF_8000_0000);
    send64(OP_SLL, 64'hFFFF_FFFF_0000_0001, 64'h1F, 1'b1, 5'd16, 64'hFFFF_FFFF_8000_0000);
    drain64();
    @(posedge clk); #1;

    // Back-to-back tags 1..6 against a stalled consumer.
    b64.out_ready_i = 1'b0;
    fork
      begin
        for (int t = 1; t <= 6; t++)
          send64(OP_ADD, 64'(t * 100), 64'(t), 1'b0, 5'(t), 64'(t * 101));
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!b64.out_valid_o && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("stall_first_valid", 64'(b64.out_valid_o), 64'd1);
        chk("stall_in_ready_low", 64'(b64.in_ready_o), 64'd0);
        chk("stall_first_tag", 64'(b64.tag_o), 64'd1);
        repeat (5) begin
          @(negedge clk);
          chk("stall_hold_res", b64.alu_res_o, 64'd101);
          chk("stall_hold_tag", 64'(b64.tag_o), 64'd1);
          chk("stall_hold_ready", 64'(b64.in_ready_o), 64'd0);
        end
        @(posedge clk); #1;
        b64.out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (k == 0) chk("bubble_free_ready", 64'(b64.in_ready_o), 64'd1);
          chk("stream_valid", 64'(b64.out_valid_o), 64'd1);
          chk("stream_tag", 64'(b64.tag_o), 64'(k + 1));
        end
        @(negedge clk);
        chk("stream_end", 64'(b64.out_valid_o), 64'd0);
      end
    join
    @(posedge clk); #1;
    drain64();
    @(posedge clk); #1;

    // Flush with two ops in flight and a third presented.
    b64.out_ready_i = 1'b0;
    send64(OP_ADD, 64'd10, 64'd20, 1'b0, 5'd20, 64'd30);
    send64(OP_ADD, 64'd11, 64'd20, 1'b0, 5'd21, 64'd31);
    b64.in_valid_i = 1'b1; b64.alu_func_i = OP_ADD; b64.opr_a_i = 64'd12;
    b64.opr_b_i = 64'd20; b64.word_op_i = 1'b0; b64.tag_i = 5'd22;
    b64.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_cycle_valid", 64'(b64.out_valid_o), 64'd0);
    @(posedge clk); #1;
    b64.flush_i = 1'b0;
    b64.in_valid_i = 1'b0;
    b64.out_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_flush_valid", 64'(b64.out_valid_o), 64'd0);
    end
    @(posedge clk); #1;
    send64(OP_SUB, 64'd100, 64'd1, 1'b0, 5'd23, 64'd99);
    lat64("after_flush", 64'd99, 5'd23);
    drain64();

    // 32-bit, single-stage instance.
    send32(OP_SUB, 32'd0, 32'd1, 1'b1, 5'd2, 32'hFFFF_FFFF);
    lat32("sub32", 32'hFFFF_FFFF, 5'd2);
    send32(OP_SRA, 32'h8000_0000, 32'h21, 1'b0, 5'd4, 32'hC000_0000);
    lat32("sra32", 32'hC000_0000, 5'd4);
    send32(OP_SLT, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd5, 32'd1);
    lat32("slt32", 32'd1, 5'd5);

    // Reset in the middle of a presented result.
    send32(OP_ADD, 32'd5, 32'd6, 1'b0, 5'd9, 32'd11);
    chk("pre_rst32_valid", 64'(b32.out_valid_o), 64'd1);
    #2;
    rst32_n = 1'b0;
    #1;
    chk("rst32_mid_valid", 64'(b32.out_valid_o), 64'd0);
    chk("rst32_mid_ready", 64'(b32.in_ready_o), 64'd1);
    chk("rst32_mid_res", 64'(b32.alu_res_o), 64'd0);
    chk("rst32_mid_tag", 64'(b32.tag_o), 64'd0);
    @(negedge clk); #2;
    rst32_n = 1'b1;
    @(negedge clk);
    chk("post_rst32_valid", 64'(b32.out_valid_o), 64'd0);
    chk("post_rst32_ready", 64'(b32.in_ready_o), 64'd1);
    @(posedge clk); #1;
    send32(OP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 5'd6, 32'hF0F0_F0F0);
    lat32("xor32", 32'hF0F0_F0F0, 5'd6);
    chk("q32_empty", 64'(q32.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
